// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle RV64 subset sequencer: FSM states,
// opcodes, ALU operation codes and ALU operand selects.
package mc_control_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    EXEC_R  = 4'd2,
    WB_R    = 4'd3,
    ADDR    = 4'd4,
    MEM_LD  = 4'd5,
    WB_LD   = 4'd6,
    MEM_SD  = 4'd7,
    BRANCH  = 4'd8,
    ILLEGAL = 4'd9
  } state_t;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_SD    = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Funct is {IR[30], IR[14:12]}
  localparam logic [3:0] FUNCT_ADD = 4'b0000;
  localparam logic [3:0] FUNCT_SUB = 4'b1000;
  localparam logic [3:0] FUNCT_AND = 4'b0111;
  localparam logic [3:0] FUNCT_OR  = 4'b0110;

  function automatic logic rtype_funct_ok(input logic [3:0] funct);
    return (funct == FUNCT_ADD) || (funct == FUNCT_SUB) ||
           (funct == FUNCT_AND) || (funct == FUNCT_OR);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bus between the multi-cycle sequencer (master) and the datapath
// (slave): instruction fields and status in, strobes and selects out.
interface multicycle_control_if;
  logic [6:0]  Opcode;
  logic [3:0]  Funct;
  logic        Zero;
  logic        MemReady;
  logic        PCWrite;
  logic        PCSrc;
  logic        IorD;
  logic        MemRead;
  logic        MemWrite;
  logic        IRWrite;
  logic        MemtoReg;
  logic        RegWrite;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic        Branch;
  logic [3:0]  Operation;
  logic        Illegal;
  logic [31:0] CycleCount;
  logic [31:0] InstrCount;

  modport master (
    input  Opcode, Funct, Zero, MemReady,
    output PCWrite, PCSrc, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegWrite, ALUSrcA, ALUSrcB, Branch, Operation, Illegal,
           CycleCount, InstrCount
  );

  modport slave (
    output Opcode, Funct, Zero, MemReady,
    input  PCWrite, PCSrc, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegWrite, ALUSrcA, ALUSrcB, Branch, Operation, Illegal,
           CycleCount, InstrCount
  );
endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// ALU control decode: FSM-selected ALUOp (add / sub / by funct) to the
// 4-bit ALU Operation code.
module alu_decoder
  import mc_control_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [3:0] funct,
  output logic [3:0] operation
);

  always_comb begin
    operation = ALU_ADD;
    case (alu_op)
      ALUOP_SUB:   operation = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_SUB: operation = ALU_SUB;
          FUNCT_AND: operation = ALU_AND;
          FUNCT_OR:  operation = ALU_OR;
          default:   operation = ALU_ADD;
        endcase
      end
      default:     operation = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle Moore sequencer for the RV64 add/sub/and/or, ld, sd, beq subset.
// Optional performance counters are built when MC_PERF_COUNT_EN is defined.
module multicycle_control
  import mc_control_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  multicycle_control_if.master bus
);

  state_t     state;
  state_t     next_state;
  logic [1:0] alu_op;
  logic       alu_en;
  logic [3:0] dec_operation;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= next_state;
  end

  // Outputs are forced low while reset is held so an in-flight access drops at once
  always_comb begin
    next_state    = state;
    alu_op        = ALUOP_ADD;
    alu_en        = 1'b0;
    bus.PCWrite   = 1'b0;
    bus.PCSrc     = 1'b0;
    bus.IorD      = 1'b0;
    bus.MemRead   = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.IRWrite   = 1'b0;
    bus.MemtoReg  = 1'b0;
    bus.RegWrite  = 1'b0;
    bus.ALUSrcA   = 1'b0;
    bus.ALUSrcB   = SRCB_RS2;
    bus.Branch    = 1'b0;
    bus.Illegal   = 1'b0;
    if (!reset) begin
      case (state)
        FETCH: begin
          bus.MemRead = 1'b1;
          bus.ALUSrcB = SRCB_FOUR;
          alu_en      = 1'b1;
          if (bus.MemReady) begin
            bus.IRWrite = 1'b1;
            bus.PCWrite = 1'b1;
            next_state  = DECODE;
          end
        end
        DECODE: begin
          bus.ALUSrcB = SRCB_IMM;
          alu_en      = 1'b1;
          case (bus.Opcode)
            OP_RTYPE:     next_state = rtype_funct_ok(bus.Funct) ? EXEC_R : ILLEGAL;
            OP_LD, OP_SD: next_state = ADDR;
            OP_BEQ:       next_state = BRANCH;
            default:      next_state = ILLEGAL;
          endcase
        end
        EXEC_R: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = SRCB_RS2;
          alu_op      = ALUOP_FUNCT;
          alu_en      = 1'b1;
          next_state  = WB_R;
        end
        WB_R: begin
          bus.RegWrite = 1'b1;
          next_state   = FETCH;
        end
        ADDR: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = SRCB_IMM;
          alu_en      = 1'b1;
          if (bus.Opcode == OP_LD)      next_state = MEM_LD;
          else if (bus.Opcode == OP_SD) next_state = MEM_SD;
          else                          next_state = ILLEGAL;
        end
        MEM_LD: begin
          bus.MemRead = 1'b1;
          bus.IorD    = 1'b1;
          if (bus.MemReady) next_state = WB_LD;
        end
        WB_LD: begin
          bus.RegWrite = 1'b1;
          bus.MemtoReg = 1'b1;
          next_state   = FETCH;
        end
        MEM_SD: begin
          bus.MemWrite = 1'b1;
          bus.IorD     = 1'b1;
          if (bus.MemReady) next_state = FETCH;
        end
        BRANCH: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = SRCB_RS2;
          alu_op      = ALUOP_SUB;
          alu_en      = 1'b1;
          bus.Branch  = 1'b1;
          bus.PCSrc   = 1'b1;
          bus.PCWrite = bus.Zero;
          next_state  = FETCH;
        end
        ILLEGAL: begin
          bus.Illegal = 1'b1;
        end
        default: next_state = FETCH;
      endcase
    end
  end

  alu_decoder u_alu_decoder (
    .alu_op    (alu_op),
    .funct     (bus.Funct),
    .operation (dec_operation)
  );

  // Operation reads as 0 in states that do not drive the ALU
  assign bus.Operation = alu_en ? dec_operation : ALU_AND;

`ifdef MC_PERF_COUNT_EN
  logic [31:0] cycle_count;
  logic [31:0] instr_count;
  logic        retire;

  assign retire = (state == WB_R) || (state == WB_LD) || (state == BRANCH) ||
                  ((state == MEM_SD) && bus.MemReady);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      if (state != ILLEGAL) cycle_count <= cycle_count + 32'd1;
      if (retire)           instr_count <= instr_count + 32'd1;
    end
  end

  assign bus.CycleCount = cycle_count;
  assign bus.InstrCount = instr_count;
`else
  assign bus.CycleCount = '0;
  assign bus.InstrCount = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle vector table plus reset,
// wait-state and illegal-instruction sequences.
module tb_multicycle_control;

  typedef struct {
    logic [6:0]  opcode;
    logic [3:0]  funct;
    logic        zero;
    logic        mready;
    logic [16:0] exp;
  } vec_t;

`ifdef MC_PERF_COUNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_LD  = 7'b0000011;
  localparam logic [6:0] OPC_SD  = 7'b0100011;
  localparam logic [6:0] OPC_BEQ = 7'b1100011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   ret = 0;
  vec_t tbl[$];

  logic [16:0] F_RDY, F_WAIT, DEC, WBR, ADR, MLD, WBLD, MSD, ILL, BR1, BR0;
  logic [16:0] EX_ADD, EX_SUB, EX_AND, EX_OR;

  multicycle_control_if bus();

  multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // {PCWrite,PCSrc,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,Branch,Operation,Illegal}
  function automatic logic [16:0] mk(input logic pcw, input logic pcsrc, input logic iord,
                                     input logic mr, input logic mw, input logic irw,
                                     input logic m2r, input logic rw, input logic srca,
                                     input logic [1:0] srcb, input logic br,
                                     input logic [3:0] op, input logic ill);
    return {pcw, pcsrc, iord, mr, mw, irw, m2r, rw, srca, srcb, br, op, ill};
  endfunction

  function automatic logic [16:0] outs();
    return {bus.PCWrite, bus.PCSrc, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
            bus.MemtoReg, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.Branch,
            bus.Operation, bus.Illegal};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic add(input logic [6:0] op, input logic [3:0] f, input logic z,
                     input logic mr, input logic [16:0] e);
    vec_t v;
    v.opcode = op; v.funct = f; v.zero = z; v.mready = mr; v.exp = e;
    tbl.push_back(v);
  endtask

  // Drive one cycle's inputs, check outputs and counters, then advance the model
  task automatic run_vec(input vec_t v, input string nm);
    bus.Opcode   = v.opcode;
    bus.Funct    = v.funct;
    bus.Zero     = v.zero;
    bus.MemReady = v.mready;
    #1;
    chk({nm, "_outs"}, {15'd0, outs()}, {15'd0, v.exp});
    chk({nm, "_cycles"}, bus.CycleCount, PERF ? cyc : 0);
    chk({nm, "_instrs"}, bus.InstrCount, PERF ? ret : 0);
    if (v.exp != ILL) cyc++;
    if (v.exp == WBR || v.exp == WBLD || v.exp[5] || (v.exp == MSD && v.mready)) ret++;
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    reset = 1'b1;
    #2;
    chk({nm, "_rst_outs"}, {15'd0, outs()}, 32'd0);
    chk({nm, "_rst_cycles"}, bus.CycleCount, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    cyc = 0;
    ret = 0;
  endtask

  task automatic run_table(input string nm);
    foreach (tbl[i]) begin
      @(negedge clk);
      run_vec(tbl[i], $sformatf("%s%0d", nm, i));
    end
    tbl.delete();
  endtask

  initial begin
    F_RDY  = mk(1,0,0,1,0,1,0,0,0,2'b01,0,4'b0010,0);
    F_WAIT = mk(0,0,0,1,0,0,0,0,0,2'b01,0,4'b0010,0);
    DEC    = mk(0,0,0,0,0,0,0,0,0,2'b10,0,4'b0010,0);
    EX_ADD = mk(0,0,0,0,0,0,0,0,1,2'b00,0,4'b0010,0);
    EX_SUB = mk(0,0,0,0,0,0,0,0,1,2'b00,0,4'b0110,0);
    EX_AND = mk(0,0,0,0,0,0,0,0,1,2'b00,0,4'b0000,0);
    EX_OR  = mk(0,0,0,0,0,0,0,0,1,2'b00,0,4'b0001,0);
    WBR    = mk(0,0,0,0,0,0,0,1,0,2'b00,0,4'b0000,0);
    ADR    = mk(0,0,0,0,0,0,0,0,1,2'b10,0,4'b0010,0);
    MLD    = mk(0,0,1,1,0,0,0,0,0,2'b00,0,4'b0000,0);
    WBLD   = mk(0,0,0,0,0,0,1,1,0,2'b00,0,4'b0000,0);
    MSD    = mk(0,0,1,0,1,0,0,0,0,2'b00,0,4'b0000,0);
    BR1    = mk(1,1,0,0,0,0,0,0,1,2'b00,1,4'b0110,0);
    BR0    = mk(0,1,0,0,0,0,0,0,1,2'b00,1,4'b0110,0);
    ILL    = mk(0,0,0,0,0,0,0,0,0,2'b00,0,4'b0000,1);

    reset = 1'b1;
    bus.Opcode = OPC_R; bus.Funct = 4'b0000; bus.Zero = 1'b0; bus.MemReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", {15'd0, outs()}, 32'd0);
    chk("reset_cycles", bus.CycleCount, 32'd0);
    chk("reset_instrs", bus.InstrCount, 32'd0);
    reset = 1'b0;

    // Main table: each R-type op, fetch wait, ld/sd with and without waits, beq both ways
    add(OPC_R, 4'b1000, 0, 1, F_RDY); add(OPC_R, 4'b1000, 0, 0, DEC);
    add(OPC_R, 4'b1000, 0, 0, EX_SUB); add(OPC_R, 4'b1000, 0, 1, WBR);
    add(OPC_R, 4'b0000, 0, 0, F_WAIT); add(OPC_R, 4'b0000, 0, 1, F_RDY);
    add(OPC_R, 4'b0000, 1, 1, DEC); add(OPC_R, 4'b0000, 1, 1, EX_ADD);
    add(OPC_R, 4'b0000, 0, 0, WBR);
    add(OPC_R, 4'b0111, 0, 1, F_RDY); add(OPC_R, 4'b0111, 0, 1, DEC);
    add(OPC_R, 4'b0111, 0, 1, EX_AND); add(OPC_R, 4'b0111, 0, 1, WBR);
    add(OPC_R, 4'b0110, 0, 1, F_RDY); add(OPC_R, 4'b0110, 0, 1, DEC);
    add(OPC_R, 4'b0110, 0, 1, EX_OR); add(OPC_R, 4'b0110, 0, 1, WBR);
    add(OPC_LD, 4'b0011, 0, 1, F_RDY); add(OPC_LD, 4'b0011, 0, 1, DEC);
    add(OPC_LD, 4'b0011, 0, 1, ADR); add(OPC_LD, 4'b0011, 0, 1, MLD);
    add(OPC_LD, 4'b0011, 0, 1, WBLD);
    add(OPC_LD, 4'b0011, 0, 1, F_RDY); add(OPC_LD, 4'b0011, 0, 0, DEC);
    add(OPC_LD, 4'b0011, 0, 0, ADR);
    for (int k = 0; k < 3; k++) add(OPC_LD, 4'b0011, 0, 0, MLD);
    add(OPC_LD, 4'b0011, 0, 1, MLD); add(OPC_LD, 4'b0011, 0, 0, WBLD);
    add(OPC_SD, 4'b0011, 0, 1, F_RDY); add(OPC_SD, 4'b0011, 0, 1, DEC);
    add(OPC_SD, 4'b0011, 0, 1, ADR); add(OPC_SD, 4'b0011, 0, 1, MSD);
    add(OPC_SD, 4'b0011, 0, 1, F_RDY); add(OPC_SD, 4'b0011, 0, 1, DEC);
    add(OPC_SD, 4'b0011, 0, 1, ADR); add(OPC_SD, 4'b0011, 0, 0, MSD);
    add(OPC_SD, 4'b0011, 0, 0, MSD); add(OPC_SD, 4'b0011, 0, 1, MSD);
    add(OPC_BEQ, 4'b0000, 1, 1, F_RDY); add(OPC_BEQ, 4'b0000, 1, 1, DEC);
    add(OPC_BEQ, 4'b0000, 1, 0, BR1);
    add(OPC_BEQ, 4'b0000, 0, 1, F_RDY); add(OPC_BEQ, 4'b0000, 0, 1, DEC);
    add(OPC_BEQ, 4'b0000, 0, 1, BR0);
    run_table("main");

    // Reset while MEM_LD waits: strobes drop without completion
    add(OPC_LD, 4'b0011, 0, 1, F_RDY); add(OPC_LD, 4'b0011, 0, 1, DEC);
    add(OPC_LD, 4'b0011, 0, 1, ADR); add(OPC_LD, 4'b0011, 0, 0, MLD);
    run_table("ldrst");
    #1 reset = 1'b1;
    #1;
    chk("ldrst_memread_drop", {31'd0, bus.MemRead}, 32'd0);
    chk("ldrst_outs", {15'd0, outs()}, 32'd0);
    chk("ldrst_instrs", bus.InstrCount, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    cyc = 0;
    ret = 0;
    #1;
    chk("ldrst_after_outs", {15'd0, outs()}, {15'd0, F_WAIT});
    chk("ldrst_after_cycles", bus.CycleCount, 32'd0);
    add(OPC_R, 4'b1000, 0, 1, F_RDY); add(OPC_R, 4'b1000, 0, 1, DEC);
    add(OPC_R, 4'b1000, 0, 1, EX_SUB); add(OPC_R, 4'b1000, 0, 1, WBR);
    add(OPC_R, 4'b1000, 0, 1, F_RDY);
    run_table("post_rst");

    // Unsupported opcode: sticky trap, counters frozen, no strobes
    do_reset("illop");
    add(OPC_IMM, 4'b0000, 0, 1, F_RDY); add(OPC_IMM, 4'b0000, 0, 1, DEC);
    for (int k = 0; k < 20; k++) add(OPC_R, 4'b0000, k[0], 1, ILL);
    run_table("illop");

    // R-type with an unsupported funct
    do_reset("illfn");
    add(OPC_R, 4'b0001, 0, 1, F_RDY); add(OPC_R, 4'b0001, 0, 1, DEC);
    for (int k = 0; k < 4; k++) add(OPC_BEQ, 4'b0000, 1, 1, ILL);
    run_table("illfn");

    // Reset is the only way out of ILLEGAL
    do_reset("recover");
    add(OPC_BEQ, 4'b0000, 1, 1, F_RDY); add(OPC_BEQ, 4'b0000, 1, 1, DEC);
    add(OPC_BEQ, 4'b0000, 1, 1, BR1); add(OPC_BEQ, 4'b0000, 1, 0, F_WAIT);
    run_table("recover");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencer for the RV64 subset datapath (R-type add/sub/and/or, ld, sd, beq). It replaces single-cycle main decode: a state machine steps one shared memory port, ALU and register file through fetch, decode, execute, memory and write-back. It also handles memory wait states and traps unsupported encodings.

## Interface
Parameters:
- none (encodings fixed in package)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- Opcode  in  7  IR[6:0], valid from DECODE onward
- Funct  in  4  {IR[30], IR[14:12]}
- Zero  in  1  ALU zero flag
- MemReady  in  1  memory completes the current access this cycle
- PCWrite  out  1  load PC
- PCSrc  out  1  0 = ALU result (PC+4), 1 = ALUOut (branch target)
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut
- MemRead, MemWrite  out  1 each  memory strobes
- IRWrite  out  1  load instruction register
- MemtoReg  out  1  write-back source: 0 = ALUOut, 1 = MDR
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  0 = PC, 1 = rs1
- ALUSrcB  out  2  00 = rs2, 01 = const 4, 10 = immediate
- Branch  out  1  beq compare cycle
- Operation  out  4  ALU op: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB
- Illegal  out  1  trap indicator, sticky
- CycleCount, InstrCount  out  32 each  performance counters (see Configuration)

## Operation
- Moore FSM with 4-bit state. Outputs decode from state only, except the MemReady/Zero-gated PCWrite and IRWrite.
- Default output values are all 0. Reset state is FETCH.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, Operation=ADD.
  - On MemReady: IRWrite=1, PCWrite=1, PCSrc=0, then go to DECODE.
  - Otherwise hold in FETCH.
- DECODE: ALUSrcA=0, ALUSrcB=10, Operation=ADD (precompute branch target into ALUOut). Next state:
  - Opcode 0110011 with Funct in {0000 add, 1000 sub, 0111 and, 0110 or} → EXEC_R
  - Opcode 0000011 or 0100011 → ADDR
  - Opcode 1100011 → BRANCH
  - Anything else, including an R-type with another Funct → ILLEGAL
- EXEC_R: ALUSrcA=1, ALUSrcB=00, Operation decoded from Funct (add 0010, sub 0110, and 0000, or 0001); then WB_R.
- WB_R: RegWrite=1, MemtoReg=0; then FETCH.
- ADDR: ALUSrcA=1, ALUSrcB=10, ADD. Go to MEM_LD for Opcode 0000011, MEM_SD for 0100011.
- MEM_LD: MemRead=1, IorD=1. Hold until MemReady, then WB_LD.
- WB_LD: RegWrite=1, MemtoReg=1; then FETCH.
- MEM_SD: MemWrite=1, IorD=1. Hold until MemReady, then FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, SUB, Branch=1, PCSrc=1, PCWrite=Zero; then FETCH.
- ILLEGAL: all strobes 0, Illegal=1. Absorbing state; only reset leaves it.
- MemRead and MemWrite are never both 1. Strobes stay stable throughout a wait.

## Timing
- Cycles per instruction with MemReady tied high:
  - R-type: 4
  - ld: 5
  - sd: 4
  - beq: 3
- Each memory wait cycle adds 1 cycle.
- The MemReady response is combinational into the same-cycle PCWrite/IRWrite. The state advances on the next rising edge.
- Asynchronous reset:
  - All outputs return to 0 immediately and the state goes to FETCH.
  - Any in-flight access is abandoned; strobes drop with no completion.
  - After reset deasserts, MemRead=1 on the first cycle.
- MemReady outside FETCH/MEM_LD/MEM_SD is ignored.

## Configuration
- MC_PERF_COUNT_EN defined:
  - CycleCount increments every clock while state ≠ ILLEGAL.
  - InstrCount increments on each retire: WB_R→FETCH, WB_LD→FETCH, MEM_SD with MemReady, BRANCH→FETCH.
  - Both counters are 32-bit, wrap 0xFFFFFFFF→0, and clear on reset.
- Not defined: both ports are present and tied to 0; no counter flops are built.

## Structure
- Package mc_control_pkg holds:
  - state enum (FETCH, DECODE, EXEC_R, WB_R, ADDR, MEM_LD, WB_LD, MEM_SD, BRANCH, ILLEGAL)
  - opcode constants (OP_RTYPE, OP_LD, OP_SD, OP_BEQ)
  - ALU Operation constants
  - ALUSrcB select constants
- Sub-module alu_decoder: inputs a 2-bit ALUOp (00 add, 01 sub, 10 funct) and Funct; outputs Operation. It is instantiated once, with ALUOp driven by the FSM.

## Test plan
- Reset mid-MEM_LD (MemReady low, reset pulsed) → MemRead drops asynchronously; after release FETCH with MemRead=1, counters 0.
- R-type Opcode 0110011, Funct 1000, MemReady high → IRWrite in cycle 1, Operation 0110 in EXEC_R, RegWrite=1 MemtoReg=0 in cycle 4, InstrCount=1.
- ld (0000011) with 3 MemReady-low cycles in MEM_LD → MemRead/IorD=1 held 4 cycles, WB_LD MemtoReg=1; total 8 cycles.
- beq (1100011) with Zero=1, then Zero=0 → PCWrite=1 PCSrc=1 in BRANCH for the first, PCWrite=0 for the second; 3 cycles each.
- sd (0100011) → MemWrite=1 IorD=1 in cycle 4, MemRead=0 throughout MEM_SD, RegWrite never asserted.
- Opcode 0010011 or R-type Funct 0001 → ILLEGAL after DECODE, Illegal=1 sticky, CycleCount frozen, no strobes for 20 cycles.
